// File: rtl/asrm_bus_ctrl.sv
// System-bus controller for the asrm CPU: routes one CPU request at a time to a
// fixed-latency synchronous RAM or to an ack-handshaked I/O port with timeout.
module asrm_bus_ctrl #(
    parameter int                  WORDSIZE    = 16,
    parameter int                  RAM_LATENCY = 1,
    parameter logic [WORDSIZE-1:0] IO_BASE     = 16'hFF00,
    parameter int                  IO_TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [WORDSIZE-1:0] cpu_addr,
    input  logic [WORDSIZE-1:0] cpu_wdata,
    input  logic                cpu_we,
    output logic                cpu_ready,
    output logic [WORDSIZE-1:0] cpu_rdata,
    output logic                cpu_err,
    output logic                busy,
    output logic                ram_en,
    output logic                ram_we,
    output logic [WORDSIZE-1:0] ram_addr,
    output logic [WORDSIZE-1:0] ram_wdata,
    input  logic [WORDSIZE-1:0] ram_rdata,
    output logic                io_en,
    output logic                io_we,
    output logic [WORDSIZE-1:0] io_addr,
    output logic [WORDSIZE-1:0] io_wdata,
    input  logic [WORDSIZE-1:0] io_rdata,
    input  logic                io_ack
);

    typedef enum logic [2:0] {
        IDLE,
        RAM_ACC,
        RAM_WAIT,
        IO_WAIT,
        RESP
    } state_t;

    localparam logic [7:0] LAT = 8'(RAM_LATENCY);
    localparam logic [7:0] TMO = 8'(IO_TIMEOUT);

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic                we_q;

    logic                io_sel_d;
    logic [WORDSIZE-1:0] io_addr_d;
    logic [7:0]          cnt_inc_d;

    assign io_sel_d  = (cpu_addr >= IO_BASE);
    assign io_addr_d = cpu_addr - IO_BASE;
    assign cnt_inc_d = cnt_q + 8'd1;

    // Outputs are registered alongside the state they belong to, so each
    // strobe is visible during the cycle its state is active.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            busy      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            io_en     <= 1'b0;
            io_we     <= 1'b0;
            io_addr   <= '0;
            io_wdata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        we_q <= cpu_we;
                        busy <= 1'b1;
                        if (io_sel_d) begin
                            io_en    <= 1'b1;
                            io_we    <= cpu_we;
                            io_addr  <= io_addr_d;
                            io_wdata <= cpu_wdata;
                            cnt_q    <= '0;
                            state_q  <= IO_WAIT;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= cpu_we;
                            ram_addr  <= cpu_addr;
                            ram_wdata <= cpu_wdata;
                            state_q   <= RAM_ACC;
                        end
                    end
                end
                RAM_ACC: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (we_q) begin
                        cpu_ready <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q   <= LAT;
                        state_q <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        cpu_rdata <= ram_rdata;
                        cpu_ready <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                IO_WAIT: begin
                    // An ack on the timeout edge still counts as a normal completion.
                    if (io_ack) begin
                        if (!we_q) cpu_rdata <= io_rdata;
                        io_en     <= 1'b0;
                        io_we     <= 1'b0;
                        cpu_ready <= 1'b1;
                        state_q   <= RESP;
                    end else if (cnt_inc_d >= TMO) begin
                        if (!we_q) cpu_rdata <= '0;
                        io_en     <= 1'b0;
                        io_we     <= 1'b0;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                RESP: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asrm_bus_ctrl.sv
// Bench for asrm_bus_ctrl: directed vector table, multi-cycle corner sequences
// and randomized transactions checked against a transaction-level model.
module tb_asrm_bus_ctrl;

    localparam int          L    = 1;
    localparam int          T    = 15;
    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_err;
    logic        busy;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        io_en;
    logic        io_we;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        io_ack;

    asrm_bus_ctrl #(
        .WORDSIZE(16), .RAM_LATENCY(L), .IO_BASE(BASE), .IO_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err), .busy(busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // RAM contents as seen on the RAM port, and the model's view by CPU address.
    logic [15:0] tb_ram  [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_rdata;
    bit          pv [L];
    logic [15:0] pd [L];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          we;
        int          delay;
        logic [15:0] iod;
        int          ek;
        bit          eerr;
        logic [15:0] erd;
    } vec_t;
    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] ram_val(input logic [15:0] a);
        return tb_ram.exists(a) ? tb_ram[a] : (a ^ 16'h5A3C);
    endfunction

    function automatic logic [15:0] ref_val(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A3C);
    endfunction

    // One clock; also plays the synchronous RAM with read latency L.
    task automatic tick();
        bit          en;
        bit          w;
        logic [15:0] ad;
        logic [15:0] wd;
        en = ram_en; w = ram_we; ad = ram_addr; wd = ram_wdata;
        @(posedge clk);
        #1;
        if (en && w) tb_ram[ad] = wd;
        for (int i = L - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = en && !w;
        pd[0] = ram_val(ad);
        ram_rdata = pv[L-1] ? pd[L-1] : 16'($urandom);
    endtask

    function automatic logic [31:0] all_outs();
        return {16'(cpu_rdata | ram_addr | ram_wdata | io_addr | io_wdata),
                8'd0, cpu_ready, cpu_err, busy, ram_en, ram_we, io_en, io_we, 1'b0};
    endfunction

    // Transaction-level model: latency, error and read data from the rules alone.
    task automatic ref_txn(input logic [15:0] a, input logic [15:0] wd, input bit we,
                           input int delay, input logic [15:0] iod,
                           output int k, output bit err, output logic [15:0] rd);
        err = 1'b0;
        if (a < BASE) begin
            if (we) begin
                ref_mem[a] = wd;
                k = 2;
            end else begin
                ref_rdata = ref_val(a);
                k = 2 + L;
            end
        end else if (delay <= T) begin
            k = delay + 1;
            if (!we) ref_rdata = iod;
        end else begin
            k = T + 1;
            err = 1'b1;
            if (!we) ref_rdata = 16'h0000;
        end
        rd = ref_rdata;
    endtask

    // Issue one request, play the I/O peripheral, check strobes, return results.
    task automatic do_txn(input logic [15:0] a, input logic [15:0] wd, input bit we,
                          input int delay, input logic [15:0] iod,
                          output int k, output bit err, output logic [15:0] rd);
        int nram, nio, nbusy, nstray;
        bit fld_ok;
        bit is_io;
        nram = 0; nio = 0; nbusy = 0; nstray = 0; fld_ok = 1'b1;
        is_io = (a >= BASE);
        k = 0; err = 1'b0; rd = 16'hxxxx;
        cpu_req = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_we = we;
        for (int c = 1; c <= 40 && k == 0; c++) begin
            tick();
            io_ack   = 1'b0;
            io_rdata = 16'($urandom);
            if (io_en && c == delay) begin
                io_ack   = 1'b1;
                io_rdata = iod;
            end
            if (ram_en) begin
                nram++;
                if (ram_addr !== a || ram_we !== we || (we && ram_wdata !== wd)) fld_ok = 1'b0;
            end
            if (io_en) begin
                nio++;
                if (io_addr !== 16'(a - BASE) || io_we !== we || (we && io_wdata !== wd)) fld_ok = 1'b0;
            end
            if (busy) nbusy++;
            if (cpu_ready) begin
                k = c;
                err = cpu_err;
                rd = cpu_rdata;
                cpu_req = 1'b0;
            end else if (cpu_err) begin
                nstray++;
            end
        end
        cpu_req = 1'b0;
        io_ack  = 1'b0;
        tick();
        chk("strobe_fields", 32'(fld_ok), 32'd1);
        chk("ram_en_pulses", nram, is_io ? 0 : 1);
        chk("io_en_cycles", nio, is_io ? k - 1 : 0);
        chk("busy_cycles", nbusy, k);
        chk("idle_after", {cpu_ready, busy, io_en, ram_en, 28'(nstray)}, 32'd0);
    endtask

    int          k_o;
    bit          e_o;
    logic [15:0] r_o;
    int          k_e;
    bit          e_e;
    logic [15:0] r_e;

    initial begin
        vt[0]  = '{16'h0010, 16'h0000, 1'b0, 0,  16'h0000, 3,  1'b0, 16'hBEEF};
        vt[1]  = '{16'h0020, 16'h1234, 1'b1, 0,  16'h0000, 2,  1'b0, 16'hBEEF};
        vt[2]  = '{16'h0020, 16'h0000, 1'b0, 0,  16'h0000, 3,  1'b0, 16'h1234};
        vt[3]  = '{16'hFF04, 16'h0000, 1'b0, 3,  16'h00A5, 4,  1'b0, 16'h00A5};
        vt[4]  = '{16'hFF00, 16'h0000, 1'b0, 99, 16'hDEAD, 16, 1'b1, 16'h0000};
        vt[5]  = '{16'hFFFF, 16'h5A5A, 1'b1, 15, 16'h7777, 16, 1'b0, 16'h0000};
        vt[6]  = '{16'hFFFF, 16'h0000, 1'b0, 15, 16'h1357, 16, 1'b0, 16'h1357};
        vt[7]  = '{16'hFEFF, 16'h0000, 1'b0, 0,  16'h0000, 3,  1'b0, 16'h4242};
        vt[8]  = '{16'hFF10, 16'hAAAA, 1'b1, 1,  16'h0000, 2,  1'b0, 16'h4242};
        vt[9]  = '{16'hFF20, 16'hBBBB, 1'b1, 99, 16'h0000, 16, 1'b1, 16'h4242};
        vt[10] = '{16'h0000, 16'h0000, 1'b0, 0,  16'h0000, 3,  1'b0, 16'h0001};

        tb_ram[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        tb_ram[16'hFEFF] = 16'h4242; ref_mem[16'hFEFF] = 16'h4242;
        tb_ram[16'h0000] = 16'h0001; ref_mem[16'h0000] = 16'h0001;
        tb_ram[16'h0040] = 16'h1111; ref_mem[16'h0040] = 16'h1111;
        tb_ram[16'h0041] = 16'h2222; ref_mem[16'h0041] = 16'h2222;
        for (int i = 0; i < L; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        ref_rdata = 16'h0000;

        reset = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h0; cpu_we = 1'b0;
        io_ack = 1'b1; io_rdata = 16'h0; ram_rdata = 16'h0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 32'd0);
        cpu_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("stray_ack_ignored", {cpu_ready, busy, io_en, ram_en}, 4'd0);
        io_ack = 1'b0;

        for (int i = 0; i < 11; i++) begin
            ref_txn(vt[i].addr, vt[i].wdata, vt[i].we, vt[i].delay, vt[i].iod, k_e, e_e, r_e);
            do_txn(vt[i].addr, vt[i].wdata, vt[i].we, vt[i].delay, vt[i].iod, k_o, e_o, r_o);
            chk($sformatf("vec%0d_latency", i), k_o, vt[i].ek);
            chk($sformatf("vec%0d_err", i), 32'(e_o), 32'(vt[i].eerr));
            chk($sformatf("vec%0d_rdata", i), r_o, vt[i].erd);
        end

        // Back-to-back reads with cpu_req held through RESP.
        begin
            int nr;
            int cyc [2];
            logic [15:0] dat [2];
            nr = 0; cyc[0] = 0; cyc[1] = 0; dat[0] = '0; dat[1] = '0;
            cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_we = 1'b0;
            for (int c = 1; c <= 14; c++) begin
                tick();
                if (cpu_ready) begin
                    if (nr < 2) begin
                        cyc[nr] = c;
                        dat[nr] = cpu_rdata;
                    end
                    nr++;
                    if (nr == 1) cpu_addr = 16'h0041;
                    if (nr == 2) cpu_req = 1'b0;
                end
            end
            chk("b2b_count", nr, 2);
            chk("b2b_first_cycle", cyc[0], 2 + L);
            chk("b2b_spacing", cyc[1] - cyc[0], 3 + L);
            chk("b2b_data", {dat[0], dat[1]}, {16'h1111, 16'h2222});
            ref_rdata = 16'h2222;
        end

        // Reset asserted while a RAM read is waiting for data.
        begin
            bit seen;
            seen = 1'b0;
            cpu_req = 1'b1; cpu_addr = 16'h0030; cpu_we = 1'b0;
            tick();
            tick();
            cpu_req = 1'b0;
            reset = 1'b0;
            tick();
            seen |= cpu_ready;
            chk("midreset_outputs", all_outs(), 32'd0);
            tick();
            seen |= cpu_ready;
            reset = 1'b1;
            tick();
            seen |= cpu_ready;
            tick();
            seen |= cpu_ready;
            chk("midreset_no_ready", {seen, busy}, 2'd0);
            ref_rdata = 16'h0000;
            ref_txn(16'h0030, 16'h0, 1'b0, 0, 16'h0, k_e, e_e, r_e);
            do_txn(16'h0030, 16'h0, 1'b0, 0, 16'h0, k_o, e_o, r_o);
            chk("after_reset_txn", {k_o[7:0], 7'd0, e_o, r_o}, {k_e[7:0], 7'd0, e_e, r_e});
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            logic [15:0] wd;
            bit          we;
            int          dl;
            logic [15:0] iod;
            a   = $urandom_range(0, 1) ? (BASE | 16'($urandom_range(0, 255)))
                                       : 16'($urandom_range(0, 31));
            wd  = 16'($urandom);
            we  = 1'($urandom_range(0, 1));
            dl  = $urandom_range(1, T + 3);
            iod = 16'($urandom);
            ref_txn(a, wd, we, dl, iod, k_e, e_e, r_e);
            do_txn(a, wd, we, dl, iod, k_o, e_o, r_o);
            chk($sformatf("rnd%0d_a%04h", n, a), {k_o[7:0], 7'd0, e_o, r_o}, {k_e[7:0], 7'd0, e_e, r_e});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
